// File: rtl/core_pkg.sv
// Purpose     : shared definitions for the core memory path (response owner encoding, defaults).
// Latency     : n/a (types and constants only).
// Backpressure: n/a.
// Contents    : owner_e (OWNER_NONE/OWNER_IF/OWNER_D), STARVE_LIMIT_DEF.
package core_pkg;

  // Which requester the read data returning next cycle belongs to.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'b00,
    OWNER_IF   = 2'b01,
    OWNER_D    = 2'b10
  } owner_e;

  // Consecutive denied fetch cycles before fetch is given priority.
  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_arbiter_prio.sv
// Purpose     : combinational grant selection between fetch and data requesters.
// Latency     : 0 cycles (pure combinational).
// Backpressure: a losing requester simply sees no gnt and holds its request.
// Ports       : if_req_i, d_req_i, guard_active_i in; if_gnt_o, d_gnt_o out (one-hot or zero).
module mem_arbiter_prio (
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic guard_active_i,
  output logic if_gnt_o,
  output logic d_gnt_o
);

  // Data wins by default; fetch only wins an idle data port or when starved.
  always_comb begin
    if_gnt_o = if_req_i && (!d_req_i || guard_active_i);
    d_gnt_o  = d_req_i && !if_gnt_o;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose     : shares one single-port synchronous memory between fetch and load/store.
// Latency     : grant 0 cycles; read data/rvalid exactly 1 cycle after gnt; stores complete on gnt.
// Backpressure: requester holds req/addr/we/wdata until gnt; one access per cycle.
// Ports       : clk, rst (sync, active-high); if_* fetch port; d_* data port; mem_* memory port.
// Config      : MEM_ARBITER_STARVE_GUARD_EN adds the fetch starvation counter and guard priority;
//               without it data has strict priority and STARVE_LIMIT is ignored.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  owner_e owner_q, owner_d;
  logic   guard_active;
  logic   if_req_act, d_req_act;

  // Requests are masked during reset so no grant or strobe can leak out.
  assign if_req_act = if_req_i && !rst;
  assign d_req_act  = d_req_i && !rst;

  mem_arbiter_prio u_prio (
    .if_req_i       (if_req_act),
    .d_req_i        (d_req_act),
    .guard_active_i (guard_active),
    .if_gnt_o       (if_gnt_o),
    .d_gnt_o        (d_gnt_o)
  );

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign guard_active = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  // Counts consecutive denied fetch cycles; saturates so the guard stays
  // asserted until fetch actually gets its one grant.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_i || if_gnt_o) begin
      starve_cnt_d = '0;
    end else if (!guard_active) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = |STARVE_LIMIT;
  assign guard_active        = 1'b0;
`endif

  // Memory drive: only the granted port reaches the memory; idle bus is zero.
  always_comb begin
    mem_re_o    = if_gnt_o || (d_gnt_o && !d_we_i);
    mem_we_o    = d_gnt_o && d_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (if_gnt_o) begin
      mem_addr_o = if_addr_i;
    end else if (d_gnt_o) begin
      mem_addr_o = d_addr_i;
    end
    if (mem_we_o) begin
      mem_wdata_o = d_wdata_i;
    end
  end

  // Remember who issued this cycle's read so next cycle's data is steered back.
  always_comb begin
    owner_d = OWNER_NONE;
    if (if_gnt_o) begin
      owner_d = OWNER_IF;
    end else if (d_gnt_o && !d_we_i) begin
      owner_d = OWNER_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWNER_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // rvalid is also masked by rst so a response straddling reset assertion is dropped.
  always_comb begin
    if_rvalid_o = !rst && (owner_q == OWNER_IF);
    d_rvalid_o  = !rst && (owner_q == OWNER_D);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
    d_rdata_o   = d_rvalid_o ? mem_rdata_i : 32'h0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose     : self-checking bench for mem_arbiter with a memory model and response scoreboard.
// Latency     : checks 0-cycle grants and 1-cycle read responses.
// Backpressure: requests are re-driven every cycle by the stimulus; losing requests are dropped by the bench.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i = 1'b0, d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0, d_wdata_i = '0;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_re_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i;

  mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_gnt_o     (d_gnt_o),
    .d_rvalid_o  (d_rvalid_o),
    .d_rdata_o   (d_rdata_o),
    .mem_re_o    (mem_re_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 4) return 32'h0050_0093;  // word at byte address 0x10
    return 32'hC0DE_0000 | 32'(idx);
  endfunction

  // Memory model: synchronous single port, data one cycle after re; garbage when not read.
  logic [31:0] mem [0:255];
  logic        mem_load = 1'b1;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_we_o) begin
      mem[mem_addr_o[9:2]] <= mem_wdata_o;
    end
    mem_rdata_i <= mem_re_o ? mem[mem_addr_o[9:2]] : 32'hBAD0_BAD0;
  end

  // Reference memory and scoreboard, owned by the stimulus process.
  logic [31:0] ref_mem [0:255];
  typedef struct { int kind; logic [31:0] data; } rsp_t;  // kind 0 none, 1 fetch, 2 load
  rsp_t sb[$];
  int   m_cnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] gnt_hist = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd);
    logic eig, edg, guard;
    rsp_t er, nx;
    @(posedge clk);
    #1;
    rst = r; if_req_i = ir; if_addr_i = ia;
    d_req_i = dr; d_we_i = dw; d_addr_i = da; d_wdata_i = dwd;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
    guard = (m_cnt == LIMIT);
`else
    guard = 1'b0;
`endif
    eig = !r && ir && (!dr || guard);
    edg = !r && dr && !eig;
    @(negedge clk);
    chk("if_gnt", if_gnt_o, eig);
    chk("d_gnt", d_gnt_o, edg);
    chk("mem_re", mem_re_o, eig || (edg && !dw));
    chk("mem_we", mem_we_o, edg && dw);
    chk("mem_addr", mem_addr_o, eig ? ia : (edg ? da : 32'h0));
    if (!(edg && !dw)) chk("mem_wdata", mem_wdata_o, (edg && dw) ? dwd : 32'h0);
    gnt_hist = {gnt_hist[30:0], if_gnt_o};
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
      er.kind = 0; er.data = '0;
    end else begin
      er = sb.pop_front();
    end
    if (r) begin er.kind = 0; er.data = '0; end
    chk("if_rvalid", if_rvalid_o, er.kind == 1);
    chk("d_rvalid", d_rvalid_o, er.kind == 2);
    chk("if_rdata", if_rdata_o, (er.kind == 1) ? er.data : 32'h0);
    chk("d_rdata", d_rdata_o, (er.kind == 2) ? er.data : 32'h0);
    nx.kind = 0; nx.data = '0;
    if (eig) begin
      nx.kind = 1; nx.data = ref_mem[ia[9:2]];
    end else if (edg && !dw) begin
      nx.kind = 2; nx.data = ref_mem[da[9:2]];
    end
    if (edg && dw) ref_mem[da[9:2]] = dwd;
    sb.push_back(nx);
    if (r || !ir || eig) m_cnt = 0;
    else if (m_cnt < LIMIT) m_cnt++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rsp_t none_rsp;
    none_rsp.kind = 0; none_rsp.data = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    sb.push_back(none_rsp);

    // Reset with both requesters active: everything must stay quiet.
    step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0);
    step(1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 32'h1234);
    mem_load = 1'b0;
    idle();

    // Fetch only, then its response.
    step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();

    // Contention: load wins.
    step(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0);
    idle();

    // Store, then a load of the same word; no response for the store.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
    idle();

    // Back-to-back reads: response and new grant share a cycle.
    step(1'b0, 1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
    step(1'b0, 1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();

    // Continuous contention.
    gnt_hist = '0;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
    for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0);
    chk("guard_pattern", gnt_hist & 32'h3FF, 32'h021);
`else
    for (int c = 0; c < 20; c++) step(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0);
    chk("strict_prio", gnt_hist & 32'hFFFFF, 32'h0);
`endif
    idle();

    // Reset asserted at the edge right after a fetch grant.
    step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    sb.delete();
    sb.push_back(none_rsp);
    m_cnt = 0;
    step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 32'h1C, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();

    // Random traffic over a small address window.
    for (int c = 0; c < 60; c++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           32'($urandom_range(0, 255)) << 2, $urandom);
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
